// File: rtl/adder_8.sv
// adder_8: 8-bit ripple-carry adder with combinational result and registered copy plus signed overflow
module adder_8 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in1,
  input  logic [7:0] in2,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout,
  output logic [7:0] sum_q,
  output logic       cout_q,
  output logic       ovf_q
);
  logic [8:0] c;
  assign c[0] = cin;
  for (genvar i = 0; i < 8; i++) begin : g_fa
    assign sum[i]   = in1[i] ^ in2[i] ^ c[i];
    assign c[i+1] = (in1[i] & in2[i]) | (c[i] & (in1[i] ^ in2[i]));
  end
  assign cout = c[8];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sum_q  <= 8'h00;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      sum_q  <= sum;
      cout_q <= cout;
      ovf_q  <= c[7] ^ c[8];
    end
endmodule

// File: tb/tb_adder_8.sv
// tb_adder_8: directed and random checks of the combinational and registered adder paths
module tb_adder_8;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in1 = 8'h00, in2 = 8'h00;
  logic       cin = 1'b0;
  logic [7:0] sum, sum_q;
  logic       cout, cout_q, ovf_q;
  int checks = 0, errors = 0;

  adder_8 dut (
    .clk(clk), .rst_n(rst_n), .in1(in1), .in2(in2), .cin(cin),
    .sum(sum), .cout(cout), .sum_q(sum_q), .cout_q(cout_q), .ovf_q(ovf_q)
  );

  always #5 clk = ~clk;

  logic [25:0] tbl [10] = '{
    {8'h00, 8'h00, 1'b0, 8'h00, 1'b0},
    {8'h01, 8'h01, 1'b1, 8'h03, 1'b0},
    {8'hFF, 8'h01, 1'b0, 8'h00, 1'b1},
    {8'hFF, 8'h01, 1'b1, 8'h01, 1'b1},
    {8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1},
    {8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1},
    {8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0},
    {8'hAA, 8'h55, 1'b1, 8'h00, 1'b1},
    {8'h80, 8'h80, 1'b0, 8'h00, 1'b1},
    {8'h0F, 8'h01, 1'b0, 8'h10, 1'b0}
  };

  task automatic test_reset;
    #1;
    checks++;
    if ({sum_q, cout_q, ovf_q} !== 10'h000) begin
      errors++;
      $display("FAIL reset_regs got %h/%b/%b exp 00/0/0", sum_q, cout_q, ovf_q);
    end
  endtask

  // runs with reset held, so the registered copy must also stay cleared
  task automatic test_comb;
    logic [7:0] es;
    logic       ec;
    for (int k = 0; k < 10; k++) begin
      {in1, in2, cin, es, ec} = tbl[k];
      #2;
      checks++;
      if ({cout, sum} !== {ec, es}) begin
        errors++;
        $display("FAIL comb_%0d got %b/%h exp %b/%h", k, cout, sum, ec, es);
      end
    end
    @(negedge clk);
    checks++;
    if ({sum_q, cout_q, ovf_q} !== 10'h000) begin
      errors++;
      $display("FAIL reset_hold got %h/%b/%b exp 00/0/0", sum_q, cout_q, ovf_q);
    end
  endtask

  task automatic test_registered;
    @(negedge clk);
    rst_n = 1'b1;
    in1 = 8'h7F; in2 = 8'h01; cin = 1'b0;
    #1;
    checks++;
    if ({sum_q, cout_q, ovf_q} !== 10'h000) begin
      errors++;
      $display("FAIL pre_capture got %h/%b/%b exp 00/0/0", sum_q, cout_q, ovf_q);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({sum_q, cout_q, ovf_q} !== {8'h80, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reg_7f01 got %h/%b/%b exp 80/0/1", sum_q, cout_q, ovf_q);
    end
    in1 = 8'h12; in2 = 8'h34; cin = 1'b1;
    #3;
    checks++;
    if ({sum_q, cout_q, ovf_q} !== {8'h80, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reg_hold got %h/%b/%b exp 80/0/1", sum_q, cout_q, ovf_q);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({sum_q, cout_q, ovf_q} !== {8'h47, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reg_1234 got %h/%b/%b exp 47/0/0", sum_q, cout_q, ovf_q);
    end
  endtask

  task automatic test_async_reset;
    @(negedge clk);
    in1 = 8'hFF; in2 = 8'hFF; cin = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({sum_q, cout_q, ovf_q} !== {8'hFF, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reg_ffff got %h/%b/%b exp ff/1/0", sum_q, cout_q, ovf_q);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({sum_q, cout_q, ovf_q} !== 10'h000) begin
      errors++;
      $display("FAIL async_clear got %h/%b/%b exp 00/0/0", sum_q, cout_q, ovf_q);
    end
    checks++;
    if ({cout, sum} !== 9'h1FF) begin
      errors++;
      $display("FAIL comb_in_reset got %b/%h exp 1/ff", cout, sum);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // model uses the sign-bit rule for overflow rather than the carry pair
  task automatic test_random;
    logic [8:0] exp_full;
    logic       exp_ovf;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      in1 = 8'($urandom); in2 = 8'($urandom); cin = 1'($urandom);
      exp_full = {1'b0, in1} + {1'b0, in2} + {8'h00, cin};
      exp_ovf = (in1[7] == in2[7]) && (exp_full[7] != in1[7]);
      #2;
      checks++;
      if ({cout, sum} !== exp_full) begin
        errors++;
        $display("FAIL rand_comb %h+%h+%b got %b/%h exp %h", in1, in2, cin, cout, sum, exp_full);
      end
      @(posedge clk);
      #1;
      checks++;
      if ({cout_q, sum_q, ovf_q} !== {exp_full, exp_ovf}) begin
        errors++;
        $display("FAIL rand_reg %h+%h+%b got %b/%h/%b exp %h/%b", in1, in2, cin, cout_q, sum_q, ovf_q, exp_full, exp_ovf);
      end
    end
  endtask

  initial begin
    test_reset;
    test_comb;
    test_registered;
    test_async_reset;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/adder_8.md
ADDER_8 -- requirements
Module: adder_8

Interface
REQ-001 Parameters: none; operand width SHALL be fixed at 8 bits.
REQ-002 clk  input  1  single clock; rising edge updates the registered result copy only.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in1  input  8  unsigned addend A.
REQ-005 in2  input  8  unsigned addend B.
REQ-006 cin  input  1  carry-in, weight 1.
REQ-007 sum  output  8  combinational sum bits [7:0].
REQ-008 cout  output  1  combinational carry-out, weight 256.
REQ-009 sum_q  output  8  registered copy of sum.
REQ-010 cout_q  output  1  registered copy of cout.
REQ-011 ovf_q  output  1  registered two's-complement overflow flag.

Function
REQ-012 {cout, sum} SHALL equal in1 + in2 + cin as a 9-bit unsigned result for all 2^17 input combinations.
REQ-013 sum and cout SHALL be purely combinational, zero-cycle latency, valid within 2 ns of any input change, with no clock edge needed.
REQ-014 sum and cout SHALL NOT depend on clk or rst_n and SHALL stay correct while clk and rst_n are unconnected, X or Z.
REQ-015 The adder SHALL be a ripple-carry chain of eight 1-bit full adders: bit i sum = a^b^c; carry out = (a&b)|(c&(a^b)); c0 = cin; cout = c8.
REQ-016 Carry SHALL propagate through all 8 stages, so FF+01+0 gives 00 with cout=1, and AA+55+1 gives 00 with cout=1.
REQ-017 No saturation: results above 255 SHALL wrap modulo 256 in sum, with the overflow reported on cout.
REQ-018 Signed overflow SHALL be c7 XOR c8, where c7 is the carry into bit 7 and c8 = cout.
REQ-019 On each rising clk edge with rst_n=1: sum_q <= sum, cout_q <= cout, ovf_q <= overflow; registered outputs lag inputs by 1 cycle.
REQ-020 Registered outputs SHALL hold their value between rising edges regardless of input changes.
REQ-021 No handshake and no state machine; the block SHALL accept new operands every cycle.

Reset
REQ-022 rst_n=0 SHALL immediately (asynchronously) force sum_q=8'h00, cout_q=0 and ovf_q=0, independent of clk.
REQ-023 Registered outputs SHALL hold reset values while rst_n=0; the first capture SHALL be the first rising clk edge after rst_n deasserts.
REQ-024 Reset asserted mid-operation SHALL clear the registers at once and SHALL NOT disturb combinational sum and cout.

Verification
REQ-025 With clk/rst_n unconnected: 00+00+0 -> sum=00, cout=0; 01+01+1 -> sum=03, cout=0; each checked 2 ns after applying inputs.
REQ-026 FF+01+0 -> sum=00, cout=1; FF+01+1 -> sum=01, cout=1.
REQ-027 FF+FF+0 -> sum=FE, cout=1; FF+FF+1 -> sum=FF, cout=1.
REQ-028 AA+55+0 -> sum=FF, cout=0; AA+55+1 -> sum=00, cout=1 (full-length carry ripple).
REQ-029 Registered path: rst_n=0 -> sum_q=00, cout_q=0, ovf_q=0; release reset, apply 7F+01+0, one rising edge -> sum_q=80, cout_q=0, ovf_q=1.
REQ-030 Assert rst_n low between edges with FF+FF+1 applied -> registers clear immediately while sum=FF, cout=1 remain; exhaustive random compare against in1+in2+cin.
